// File: rtl/tl_sink_downsizer_pkg.sv
// rtl/tl_sink_downsizer_pkg.sv - TileLink channel types, D opcodes and beat helpers for the sink downsizer
package tl_sink_downsizer_pkg;

    localparam int TlDataWidth       = 64;
    localparam int TlAddrWidth       = 56;
    localparam int TlSourceWidth     = 1;
    localparam int TlHostSinkWidth   = 1;
    localparam int TlDeviceSinkWidth = 4;
    localparam int TlSizeWidth       = 4;
    localparam int TlMaskWidth       = TlDataWidth / 8;

    typedef enum logic [2:0] {
        TlAccessAck     = 3'd0,
        TlAccessAckData = 3'd1,
        TlHintAck       = 3'd2,
        TlGrant         = 3'd4,
        TlGrantData     = 3'd5,
        TlReleaseAck    = 3'd6
    } tl_d_op_e;

    typedef struct packed {
        logic [2:0]               opcode;
        logic [2:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlMaskWidth-1:0]   mask;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]               opcode;
        logic [2:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlMaskWidth-1:0]   mask;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_b_t;

    typedef struct packed {
        logic [2:0]               opcode;
        logic [2:0]               param;
        logic [TlSizeWidth-1:0]   size;
        logic [TlSourceWidth-1:0] source;
        logic [TlAddrWidth-1:0]   address;
        logic [TlDataWidth-1:0]   data;
        logic                     corrupt;
    } tl_c_t;

    typedef struct packed {
        logic [2:0]                 opcode;
        logic [1:0]                 param;
        logic [TlSizeWidth-1:0]     size;
        logic [TlSourceWidth-1:0]   source;
        logic [TlHostSinkWidth-1:0] sink;
        logic                       denied;
        logic [TlDataWidth-1:0]     data;
        logic                       corrupt;
    } tl_d_host_t;

    typedef struct packed {
        logic [2:0]                   opcode;
        logic [1:0]                   param;
        logic [TlSizeWidth-1:0]       size;
        logic [TlSourceWidth-1:0]     source;
        logic [TlDeviceSinkWidth-1:0] sink;
        logic                         denied;
        logic [TlDataWidth-1:0]       data;
        logic                         corrupt;
    } tl_d_dev_t;

    typedef struct packed {
        logic [TlHostSinkWidth-1:0] sink;
    } tl_e_host_t;

    typedef struct packed {
        logic [TlDeviceSinkWidth-1:0] sink;
    } tl_e_dev_t;

    // D messages that carry a data payload and so may span several beats
    function automatic logic tl_d_has_data(input logic [2:0] opcode);
        return (opcode == TlAccessAckData) || (opcode == TlGrantData);
    endfunction

    // Beats for a 2**size byte payload on a data_width bit bus, never less than one
    function automatic int unsigned tl_beats(input logic [TlSizeWidth-1:0] size,
                                             input int unsigned data_width);
        int unsigned bytes;
        int unsigned per_beat;
        bytes    = 32'd1 << size;
        per_beat = data_width / 8;
        if (bytes <= per_beat) begin
            return 1;
        end
        return bytes / per_beat;
    endfunction

endpackage

// File: rtl/tl_sink_id_table.sv
// rtl/tl_sink_id_table.sv - free mask, host-slot to device-sink storage and lowest-free slot encoder
module tl_sink_id_table #(
    parameter int IdxWidth  = 1,
    parameter int DataWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [IdxWidth-1:0]  alloc_idx,
    input  logic [DataWidth-1:0] alloc_data,
    input  logic                 free_valid,
    input  logic [IdxWidth-1:0]  free_idx,
    input  logic [IdxWidth-1:0]  lookup_idx,
    output logic [DataWidth-1:0] lookup_data
);

    localparam int Depth = 2 ** IdxWidth;

    logic [Depth-1:0]     free_mask;
    logic [Depth-1:0]     alloc_oh;
    logic [Depth-1:0]     free_oh;
    logic [DataWidth-1:0] table_q [Depth];
    logic                 alloc_commit;

    // Lowest-index free slot; scanning downwards lets the lowest set bit win
    always_comb begin
        alloc_gnt = 1'b0;
        alloc_idx = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_gnt = 1'b1;
                alloc_idx = IdxWidth'(i);
            end
        end
    end

    assign alloc_commit = alloc_req && alloc_gnt;
    assign alloc_oh     = alloc_commit ? (Depth'(1) << alloc_idx) : '0;
    assign free_oh      = free_valid ? (Depth'(1) << free_idx) : '0;
    assign lookup_data  = table_q[lookup_idx];

    // Allocation is decided on the old mask, so a slot freed this cycle is usable next cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            free_mask <= '1;
        end else begin
            free_mask <= (free_mask & ~alloc_oh) | free_oh;
        end
    end

    // Record which device sink owns the slot being handed out
    always_ff @(posedge clk_i) begin
        if (alloc_commit) begin
            table_q[alloc_idx] <= alloc_data;
        end
    end

    // A GrantAck must only name a slot that is currently outstanding
    free_of_busy_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        free_valid |-> !free_mask[free_idx]);

endmodule

// File: rtl/tl_sink_downsizer.sv
// rtl/tl_sink_downsizer.sv - remaps wide device sink IDs onto narrow host sink slots (optional TL_SINK_DOWNSIZER_D_REG_EN)
module tl_sink_downsizer
    import tl_sink_downsizer_pkg::*;
#(
    parameter int DataWidth       = 64,
    parameter int AddrWidth       = 56,
    parameter int SourceWidth     = 1,
    parameter int HostSinkWidth   = 1,
    parameter int DeviceSinkWidth = 4,
    parameter int MaxSize         = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,

    input  logic       host_a_valid,
    input  tl_a_t      host_a,
    output logic       host_a_ready,
    output logic       host_b_valid,
    output tl_b_t      host_b,
    input  logic       host_b_ready,
    input  logic       host_c_valid,
    input  tl_c_t      host_c,
    output logic       host_c_ready,
    output logic       host_d_valid,
    output tl_d_host_t host_d,
    input  logic       host_d_ready,
    input  logic       host_e_valid,
    input  tl_e_host_t host_e,
    output logic       host_e_ready,

    output logic       device_a_valid,
    output tl_a_t      device_a,
    input  logic       device_a_ready,
    input  logic       device_b_valid,
    input  tl_b_t      device_b,
    output logic       device_b_ready,
    output logic       device_c_valid,
    output tl_c_t      device_c,
    input  logic       device_c_ready,
    input  logic       device_d_valid,
    input  tl_d_dev_t  device_d,
    output logic       device_d_ready,
    output logic       device_e_valid,
    output tl_e_dev_t  device_e,
    input  logic       device_e_ready
);

    // The channel structs are fixed by the package; the parameter set has to agree with them
    if (DeviceSinkWidth <= HostSinkWidth || HostSinkWidth != TlHostSinkWidth ||
        DeviceSinkWidth != TlDeviceSinkWidth || DataWidth != TlDataWidth ||
        AddrWidth != TlAddrWidth || SourceWidth != TlSourceWidth) begin : g_bad_params
        $error("tl_sink_downsizer: parameters do not match the channel types");
    end

    localparam int BytesPerBeat = DataWidth / 8;
    localparam int MaxBeats     = ((2 ** MaxSize) > BytesPerBeat) ? (2 ** MaxSize) / BytesPerBeat : 1;
    localparam int CntWidth     = $clog2(MaxBeats + 1);

    logic [CntWidth-1:0]      beat_cnt;
    logic [HostSinkWidth-1:0] burst_idx;
    logic                     first_beat;
    logic                     is_grant;
    logic                     need_alloc;
    logic                     stall;
    logic                     alloc_req;
    logic                     alloc_gnt;
    logic [HostSinkWidth-1:0] alloc_idx;
    logic                     d_hs;
    logic                     d_fwd_valid;
    logic                     d_fwd_ready;
    tl_d_host_t               d_fwd;
    int unsigned              d_beats;
    logic                     free_valid;

    // A, B and C are untouched wires
    assign device_a_valid = host_a_valid;
    assign device_a       = host_a;
    assign host_a_ready   = device_a_ready;
    assign host_b_valid   = device_b_valid;
    assign host_b         = device_b;
    assign device_b_ready = host_b_ready;
    assign device_c_valid = host_c_valid;
    assign device_c       = host_c;
    assign host_c_ready   = device_c_ready;

    // Only the first beat of a Grant/GrantData needs a slot; later beats reuse burst_idx
    assign first_beat  = (beat_cnt == '0);
    assign is_grant    = (device_d.opcode == TlGrant) || (device_d.opcode == TlGrantData);
    assign need_alloc  = device_d_valid && first_beat && is_grant;
    assign stall       = need_alloc && !alloc_gnt;
    assign d_fwd_valid = rst_ni && device_d_valid && !stall;
    assign device_d_ready = rst_ni && d_fwd_ready && !stall;
    assign d_hs        = device_d_valid && device_d_ready;
    assign alloc_req   = d_hs && need_alloc;
    assign d_beats     = tl_d_has_data(device_d.opcode) ? tl_beats(device_d.size, DataWidth) : 1;

    // Remapped D beat: only the sink field changes, and non-Grant messages carry sink 0
    always_comb begin
        d_fwd.opcode  = device_d.opcode;
        d_fwd.param   = device_d.param;
        d_fwd.size    = device_d.size;
        d_fwd.source  = device_d.source;
        d_fwd.denied  = device_d.denied;
        d_fwd.data    = device_d.data;
        d_fwd.corrupt = device_d.corrupt;
        d_fwd.sink    = '0;
        if (is_grant) begin
            d_fwd.sink = first_beat ? alloc_idx : burst_idx;
        end
    end

    // Beat counter and latched slot for the message currently crossing D
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt  <= '0;
            burst_idx <= '0;
        end else if (d_hs) begin
            if (first_beat) begin
                beat_cnt <= CntWidth'(d_beats - 1);
                if (alloc_req) begin
                    burst_idx <= alloc_idx;
                end
            end else begin
                beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

`ifdef TL_SINK_DOWNSIZER_D_REG_EN
    tl_d_host_t main_q;
    tl_d_host_t skid_q;
    logic       main_valid;
    logic       skid_valid;

    assign d_fwd_ready  = !skid_valid;
    assign host_d_valid = main_valid;
    assign host_d       = main_q;

    // Two-entry skid slice: the skid entry catches the beat accepted while the output stalls
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (host_d_ready || !main_valid) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_q     <= d_fwd;
                main_valid <= d_fwd_valid;
            end
        end else if (d_fwd_valid && d_fwd_ready) begin
            skid_q     <= d_fwd;
            skid_valid <= 1'b1;
        end
    end
`else
    assign d_fwd_ready  = host_d_ready;
    assign host_d_valid = d_fwd_valid;
    assign host_d       = d_fwd;
`endif

    // E passes straight through; the host slot is translated back and freed on handshake
    assign device_e_valid = rst_ni && host_e_valid;
    assign host_e_ready   = rst_ni && device_e_ready;
    assign free_valid     = rst_ni && host_e_valid && device_e_ready;

    tl_sink_id_table #(
        .IdxWidth  (HostSinkWidth),
        .DataWidth (DeviceSinkWidth)
    ) u_id_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_idx   (alloc_idx),
        .alloc_data  (device_d.sink),
        .free_valid  (free_valid),
        .free_idx    (host_e.sink),
        .lookup_idx  (host_e.sink),
        .lookup_data (device_e.sink)
    );

endmodule

// File: tb/tb_tl_sink_downsizer.sv
// tb/tb_tl_sink_downsizer.sv - directed self-checking bench for tl_sink_downsizer
module tb_tl_sink_downsizer;
    import tl_sink_downsizer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       host_a_valid, host_a_ready, host_b_valid, host_b_ready, host_c_valid, host_c_ready;
    logic       host_d_valid, host_d_ready, host_e_valid, host_e_ready;
    logic       device_a_valid, device_a_ready, device_b_valid, device_b_ready, device_c_valid, device_c_ready;
    logic       device_d_valid, device_d_ready, device_e_valid, device_e_ready;
    tl_a_t      host_a, device_a;
    tl_b_t      host_b, device_b;
    tl_c_t      host_c, device_c;
    tl_d_host_t host_d;
    tl_d_dev_t  device_d;
    tl_e_host_t host_e;
    tl_e_dev_t  device_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_sink_downsizer dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .host_a_valid   (host_a_valid),
        .host_a         (host_a),
        .host_a_ready   (host_a_ready),
        .host_b_valid   (host_b_valid),
        .host_b         (host_b),
        .host_b_ready   (host_b_ready),
        .host_c_valid   (host_c_valid),
        .host_c         (host_c),
        .host_c_ready   (host_c_ready),
        .host_d_valid   (host_d_valid),
        .host_d         (host_d),
        .host_d_ready   (host_d_ready),
        .host_e_valid   (host_e_valid),
        .host_e         (host_e),
        .host_e_ready   (host_e_ready),
        .device_a_valid (device_a_valid),
        .device_a       (device_a),
        .device_a_ready (device_a_ready),
        .device_b_valid (device_b_valid),
        .device_b       (device_b),
        .device_b_ready (device_b_ready),
        .device_c_valid (device_c_valid),
        .device_c       (device_c),
        .device_c_ready (device_c_ready),
        .device_d_valid (device_d_valid),
        .device_d       (device_d),
        .device_d_ready (device_d_ready),
        .device_e_valid (device_e_valid),
        .device_e       (device_e),
        .device_e_ready (device_e_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [3:0] size, input logic [3:0] sink);
        device_d_valid   = v;
        device_d.opcode  = op;
        device_d.size    = size;
        device_d.sink    = sink;
        device_d.data    = 64'hA5A5_0000_0000_0000 | 64'(sink);
    endtask

    task automatic set_e(input logic v, input logic sink);
        host_e_valid = v;
        host_e.sink  = sink;
    endtask

    initial begin
        rst_ni         = 1'b0;
        host_a         = '0;
        host_b_ready   = 1'b1;
        host_c         = '0;
        host_c_valid   = 1'b0;
        host_d_ready   = 1'b1;
        host_e         = '0;
        device_a_ready = 1'b1;
        device_b       = '0;
        device_b_valid = 1'b0;
        device_c_ready = 1'b1;
        device_d       = '0;
        device_e_ready = 1'b1;
        host_a_valid   = 1'b1;
        host_a.opcode  = 3'd4;
        host_a.address = 56'h12_3456_789A;
        set_d(1'b1, TlGrant, 4'd0, 4'hA);
        set_e(1'b1, 1'b0);
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_host_d_valid", host_d_valid, 0);
        chk("rst_device_d_ready", device_d_ready, 0);
        chk("rst_device_e_valid", device_e_valid, 0);
        chk("rst_a_valid", device_a_valid, 1);
        chk("rst_a_addr", device_a.address, 56'h12_3456_789A);
        cyc();
        rst_ni = 1'b1;
        set_d(1'b0, TlGrant, 4'd0, 4'h0);
        set_e(1'b0, 1'b0);

        // B and C pass-through, A ready pass-through
        device_b_valid   = 1'b1;
        device_b.address = 56'hAB_CDEF_0123;
        host_c_valid     = 1'b1;
        host_c.data      = 64'hDEAD_BEEF_0123_4567;
        device_a_ready   = 1'b0;
        @(negedge clk);
        chk("b_valid", host_b_valid, 1);
        chk("b_addr", host_b.address, 56'hAB_CDEF_0123);
        chk("c_valid", device_c_valid, 1);
        chk("c_data", device_c.data, 64'hDEAD_BEEF_0123_4567);
        chk("a_ready", host_a_ready, 0);
        cyc();
        device_b_valid = 1'b0;
        host_c_valid   = 1'b0;
        device_a_ready = 1'b1;

        // Two Grants fill both slots in order
        set_d(1'b1, TlGrant, 4'd0, 4'hA);
        @(negedge clk);
        chk("g_a_valid", host_d_valid, 1);
        chk("g_a_sink", host_d.sink, 0);
        chk("g_a_ready", device_d_ready, 1);
        cyc();
        set_d(1'b1, TlGrant, 4'd0, 4'hC);
        @(negedge clk);
        chk("g_c_sink", host_d.sink, 1);
        cyc();

        // GrantAck for slot 0 returns device sink 0xA and frees slot 0
        set_d(1'b0, TlGrant, 4'd0, 4'h0);
        set_e(1'b1, 1'b0);
        @(negedge clk);
        chk("e0_valid", device_e_valid, 1);
        chk("e0_sink", device_e.sink, 4'hA);
        chk("e0_ready", host_e_ready, 1);
        cyc();
        set_e(1'b0, 1'b0);
        set_d(1'b1, TlGrant, 4'd0, 4'hD);
        @(negedge clk);
        chk("g_d_valid", host_d_valid, 1);
        chk("g_d_sink", host_d.sink, 0);
        cyc();

        // Table full: third Grant stalls
        set_d(1'b1, TlGrant, 4'd0, 4'h7);
        @(negedge clk);
        chk("full_ready", device_d_ready, 0);
        chk("full_valid", host_d_valid, 0);
        cyc();
        // Slot 1 freed in the same cycle: still stalled this cycle
        set_e(1'b1, 1'b1);
        @(negedge clk);
        chk("same_cycle_ready", device_d_ready, 0);
        chk("same_cycle_e_sink", device_e.sink, 4'hC);
        cyc();
        set_e(1'b0, 1'b0);
        @(negedge clk);
        chk("after_free_valid", host_d_valid, 1);
        chk("after_free_sink", host_d.sink, 1);
        chk("after_free_ready", device_d_ready, 1);
        cyc();

        // Release both slots
        set_d(1'b0, TlGrant, 4'd0, 4'h0);
        set_e(1'b1, 1'b0);
        @(negedge clk);
        chk("e_free0_sink", device_e.sink, 4'hD);
        cyc();
        set_e(1'b1, 1'b1);
        @(negedge clk);
        chk("e_free1_sink", device_e.sink, 4'h7);
        cyc();
        set_e(1'b0, 1'b0);

        // GrantData of 64 bytes = 8 beats, with one back-pressure cycle mid-burst
        for (int c = 0; c < 9; c++) begin
            host_d_ready = (c != 3);
            set_d(1'b1, TlGrantData, 4'd6, 4'h3);
            @(negedge clk);
            if (c != 3) begin
                chk("gd_valid", host_d_valid, 1);
                chk("gd_sink", host_d.sink, 0);
            end else begin
                chk("gd_backpressure", device_d_ready, 0);
            end
            cyc();
        end
        host_d_ready = 1'b1;

        // AccessAckData 8 bytes: single beat, sink 0, no slot used
        set_d(1'b1, TlAccessAckData, 4'd3, 4'hF);
        @(negedge clk);
        chk("aad_valid", host_d_valid, 1);
        chk("aad_sink", host_d.sink, 0);
        chk("aad_opcode", host_d.opcode, 1);
        chk("aad_data", host_d.data, 64'hA5A5_0000_0000_000F);
        cyc();

        // Only slot 0 was consumed by the GrantData, so slot 1 is next
        set_d(1'b1, TlGrant, 4'd0, 4'h9);
        @(negedge clk);
        chk("g_9_sink", host_d.sink, 1);
        chk("g_9_valid", host_d_valid, 1);
        cyc();
        set_d(1'b1, TlGrant, 4'd0, 4'h2);
        @(negedge clk);
        chk("g_2_stall", device_d_ready, 0);
        cyc();
        set_d(1'b0, TlGrant, 4'd0, 4'h0);
        set_e(1'b1, 1'b1);
        @(negedge clk);
        chk("e_9_sink", device_e.sink, 4'h9);
        cyc();
        set_e(1'b1, 1'b0);
        @(negedge clk);
        chk("e_3_sink", device_e.sink, 4'h3);
        cyc();
        set_e(1'b0, 1'b0);

        // Non-Grant opcode with a nonzero device sink maps to host sink 0
        set_d(1'b1, TlReleaseAck, 4'd0, 4'hE);
        @(negedge clk);
        chk("rla_sink", host_d.sink, 0);
        chk("rla_opcode", host_d.opcode, 6);
        cyc();
        set_d(1'b0, TlGrant, 4'd0, 4'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
